// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Two requesters share one 32-bit logical left shifter. Each requester
//   hands over an operand and a shift amount with a valid/ready handshake.
//   The operation is registered, shifted, and returned on a single response
//   channel together with the id of the requester that issued it. Only one
//   operation is in flight at a time.
//
//   Sequence per operation: IDLE (accept) -> SHIFT -> HOLD (until consumed).
//   The response appears two cycles after the accept cycle. The minimum
//   issue interval is three cycles.
//
// Configuration macro
//   SHIFT_ARB_RR_EN  defined   : round-robin arbitration between the two
//                                requesters, using a 1-bit preference pointer.
//                    undefined : fixed priority, where requester 0 wins. In
//                                this build no pointer register exists.
//
// Ports
//   clock, reset_n            clock, and synchronous active-low reset
//   req0_valid/ready/a/shamt  requester 0 handshake and operands
//   req1_valid/ready/a/shamt  requester 1 handshake and operands
//   rsp_valid/ready           response handshake
//   rsp_b                     shifted result (a << shamt, zero fill)
//   rsp_id                    requester that issued the result
//   busy                      high whenever an operation is in flight
module shift_arbiter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [SHAMT_W-1:0] req1_shamt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_b,
  output logic               rsp_id,
  output logic               busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]         state_reg, state_next;
  logic               grant0, grant1;
  logic               accept;
  logic [DATA_W-1:0]  op_a_reg;
  logic [SHAMT_W-1:0] op_shamt_reg;
  logic               op_id_reg;
  logic [DATA_W-1:0]  rsp_b_reg;
  logic               rsp_id_reg;

`ifdef SHIFT_ARB_RR_EN
  // ptr_reg names the preferred requester. It matters only when both
  // requesters are valid. A lone valid requester is always granted.
  logic ptr_reg;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0 = ~ptr_reg;
      grant1 = ptr_reg;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  // After every grant, prefer the requester that did not win.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr_reg <= 1'b0;
    end else if (accept) begin
      ptr_reg <= ~req1_ready;
    end
  end
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`endif

  // reset_n gates ready, so no handshake can complete while reset is held.
  assign req0_ready = reset_n & (state_reg == IDLE) & grant0;
  assign req1_ready = reset_n & (state_reg == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)    state_next = SHIFT;
      SHIFT:                  state_next = HOLD;
      HOLD:    if (rsp_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      op_a_reg     <= '0;
      op_shamt_reg <= '0;
      op_id_reg    <= 1'b0;
      rsp_b_reg    <= '0;
      rsp_id_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_a_reg     <= req1_ready ? req1_a : req0_a;
        op_shamt_reg <= req1_ready ? req1_shamt : req0_shamt;
        op_id_reg    <= req1_ready;
      end
      // The shifter output is captured at the end of SHIFT. After that it
      // stays frozen through HOLD until the response is consumed.
      if (state_reg == SHIFT) begin
        rsp_b_reg  <= op_a_reg << op_shamt_reg;
        rsp_id_reg <= op_id_reg;
      end
    end
  end

  assign rsp_valid = (state_reg == HOLD);
  assign rsp_b     = rsp_b_reg;
  assign rsp_id    = rsp_id_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed testbench for shift_arbiter.
// Inputs are driven on the falling edge of the clock.
// Outputs are sampled 1 ns after the falling edge.
module tb_shift_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_b;
  logic        rsp_id;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  shift_arbiter dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_shamt (req1_shamt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_b      (rsp_b),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  // Runs one operation from a single requester while rsp_ready is held at 1.
  // The latency is fixed, so every step is checked on its exact cycle.
  task automatic do_op(input bit sel, input logic [31:0] a, input logic [4:0] sh,
                       input logic [31:0] exp_b, input string tag);
    @(negedge clock);
    if (sel) begin req1_valid = 1'b1; req1_a = a; req1_shamt = sh; end
    else     begin req0_valid = 1'b1; req0_a = a; req0_shamt = sh; end
    #1;
    check_eq({tag, "_ready"}, sel ? req1_ready : req0_ready, 1);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check_eq({tag, "_shift_busy"}, busy, 1);
    sample();
    check_eq({tag, "_rsp_valid"}, rsp_valid, 1);
    check_eq({tag, "_rsp_b"}, rsp_b, exp_b);
    check_eq({tag, "_rsp_id"}, rsp_id, sel);
    $display("op %s id=%0d a=%h shamt=%0d b=%h", tag, sel, a, sh, rsp_b);
    sample();
    check_eq({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:0] exp_ids [4];
    logic       found;
    int         seen;

`ifdef SHIFT_ARB_RR_EN
    exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif

    reset_n    = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_a = '0; req1_shamt = '0;
    rsp_ready  = 1'b0;

    // Reset state: ready must stay low even while a request is presented.
    repeat (2) @(negedge clock);
    req0_valid = 1'b1;
    #1;
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_b", rsp_b, 0);
    check_eq("rst_rsp_id", rsp_id, 0);
    check_eq("rst_req0_ready", req0_ready, 0);
    req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // Test 1: req0 1 << 5. Response appears two cycles after the ready pulse.
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'h0000_0001; req0_shamt = 5'd5;
    #1;
    check_eq("t1_req0_ready", req0_ready, 1);
    check_eq("t1_req1_ready", req1_ready, 0);
    @(negedge clock);
    req0_valid = 1'b0;
    #1;
    check_eq("t1_shift_rsp_valid", rsp_valid, 0);
    check_eq("t1_shift_busy", busy, 1);
    sample();
    check_eq("t1_rsp_valid", rsp_valid, 1);
    check_eq("t1_rsp_b", rsp_b, 32'h0000_0020);
    check_eq("t1_rsp_id", rsp_id, 0);
    $display("op t1 id=0 a=00000001 shamt=5 b=%h", rsp_b);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    #1;
    check_eq("t1_consumed_valid", rsp_valid, 0);
    check_eq("t1_consumed_busy", busy, 0);

    // Test 2: req1 with back-pressure. req1 keeps valid asserted, but ready
    // must stay low while busy.
    @(negedge clock);
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFFF; req1_shamt = 5'd31;
    #1;
    check_eq("t2_req1_ready", req1_ready, 1);
    sample();
    check_eq("t2_shift_req1_ready", req1_ready, 0);
    for (int c = 0; c < 4; c++) begin
      sample();
      check_eq($sformatf("t2_hold%0d_valid", c), rsp_valid, 1);
      check_eq($sformatf("t2_hold%0d_b", c), rsp_b, 32'h8000_0000);
      check_eq($sformatf("t2_hold%0d_id", c), rsp_id, 1);
      check_eq($sformatf("t2_hold%0d_req1_ready", c), req1_ready, 0);
    end
    $display("op t2 id=1 a=ffffffff shamt=31 b=%h", rsp_b);
    @(negedge clock);
    rsp_ready = 1'b1;
    req1_valid = 1'b0;
    #1;
    check_eq("t2_still_valid", rsp_valid, 1);
    sample();
    check_eq("t2_consumed_busy", busy, 0);

    // Test 3: both requesters valid for four operations.
    // req0 gives 0x10 << 1 = 0x20. req1 gives 0x100 << 2 = 0x400.
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'h0000_0010; req0_shamt = 5'd1;
    req1_valid = 1'b1; req1_a = 32'h0000_0100; req1_shamt = 5'd2;
    rsp_ready  = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      found = req0_ready | req1_ready;
      for (int c = 0; c < 8 && !found; c++) begin
        sample();
        found = req0_ready | req1_ready;
      end
      check_eq($sformatf("t3_op%0d_grant_seen", i), found, 1);
      check_eq($sformatf("t3_op%0d_one_ready", i), req0_ready & req1_ready, 0);
      check_eq($sformatf("t3_op%0d_grant_id", i), req1_ready, exp_ids[i]);
      found = 1'b0;
      for (int c = 0; c < 8 && !found; c++) begin
        sample();
        found = rsp_valid;
      end
      check_eq($sformatf("t3_op%0d_rsp_seen", i), found, 1);
      check_eq($sformatf("t3_op%0d_rsp_id", i), rsp_id, exp_ids[i]);
      check_eq($sformatf("t3_op%0d_rsp_b", i), rsp_b,
               exp_ids[i] ? 32'h0000_0400 : 32'h0000_0020);
      $display("op t3.%0d id=%0d b=%h", i, rsp_id, rsp_b);
      if (i < 3) sample();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sample();
    check_eq("t3_idle", busy, 0);

    // Test 4: shift-amount boundaries.
    do_op(1'b0, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, "t4_sh0");
    do_op(1'b1, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000, "t4_sh16");
    do_op(1'b0, 32'h0000_0003, 5'd31, 32'h8000_0000, "t4_sh31");

    // Test 5: reset during SHIFT drops the operation. After reset the
    // arbiter prefers requester 0 again.
    @(negedge clock);
    rsp_ready  = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h0000_0003; req0_shamt = 5'd1;
    #1;
    check_eq("t5_req0_ready", req0_ready, 1);
    @(negedge clock);
    req0_valid = 1'b0;
    reset_n    = 1'b0;
    #1;
    check_eq("t5_in_shift_busy", busy, 1);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check_eq("t5_rst_rsp_valid", rsp_valid, 0);
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_rsp_b", rsp_b, 0);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (rsp_valid) seen++;
    end
    check_eq("t5_no_orphan_rsp", seen, 0);
    rsp_ready = 1'b1;
    @(negedge clock);
    req0_valid = 1'b1; req0_a = 32'h0000_0005; req0_shamt = 5'd2;
    req1_valid = 1'b1; req1_a = 32'h0000_0007; req1_shamt = 5'd3;
    #1;
    check_eq("t5_post_rst_req0_ready", req0_ready, 1);
    check_eq("t5_post_rst_req1_ready", req1_ready, 0);
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sample();
    check_eq("t5_post_rst_rsp_valid", rsp_valid, 1);
    check_eq("t5_post_rst_rsp_b", rsp_b, 32'h0000_0014);
    check_eq("t5_post_rst_rsp_id", rsp_id, 0);
    $display("op t5 id=0 a=00000005 shamt=2 b=%h", rsp_b);
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
